// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR and runs a req/ack fetch transaction
// with a bounded wait. The timeout substitutes a NOP and raises a sticky fault.
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_OPCODE   = '0,
  parameter int                    MAX_WAIT     = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  clock_enable,
  input  logic                  fetch_start,
  input  logic                  pc_inc,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] IR,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  ir_valid,
  output logic                  fetch_busy,
  output logic                  fetch_fault
);

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       start, ack_hit, timeout_hit, cnt_inc;

  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start       = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_start && clock_enable) begin
          start      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ack takes precedence over an expiring wait on the same edge.
        if (mem_ack) begin
          ack_hit    = 1'b1;
          state_next = S_IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      mem_req     <= 1'b0;
      mem_addr    <= RESET_VECTOR;
      IR          <= NOP_OPCODE;
      ir_valid    <= 1'b0;
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (start) begin
        mem_req  <= 1'b1;
        mem_addr <= pc;
        ir_valid <= 1'b0;
        wait_cnt <= '0;
      end
      if (ack_hit) begin
        IR       <= mem_rdata;
        ir_valid <= 1'b1;
        mem_req  <= 1'b0;
      end else if (timeout_hit) begin
        IR          <= NOP_OPCODE;
        ir_valid    <= 1'b1;
        fetch_fault <= 1'b1;
        mem_req     <= 1'b0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // PC runs independently of the fetch FSM; mem_addr keeps the in-flight address.
  always_ff @(posedge clock) begin
    if (clear) begin
      pc <= RESET_VECTOR;
    end else if (clock_enable) begin
      if (pc_load)     pc <= jump_target;
      else if (pc_inc) pc <= pc + 1'b1;
    end
  end

  assign fetch_busy = mem_req;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with default parameters (MAX_WAIT = 15).
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       clear, clock_enable, fetch_start, pc_inc, pc_load, mem_ack;
  logic [7:0] jump_target, mem_rdata;
  logic       mem_req, ir_valid, fetch_busy, fetch_fault;
  logic [7:0] mem_addr, IR, pc;

  int checks   = 0;
  int failures = 0;
  int n;

  fetch_unit dut (
    .clock        (clock),
    .clear        (clear),
    .clock_enable (clock_enable),
    .fetch_start  (fetch_start),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .jump_target  (jump_target),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .IR           (IR),
    .pc           (pc),
    .ir_valid     (ir_valid),
    .fetch_busy   (fetch_busy),
    .fetch_fault  (fetch_fault)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1; clock_enable = 1'b0; fetch_start = 1'b0; pc_inc = 1'b0;
    pc_load = 1'b0; mem_ack = 1'b0; jump_target = 8'h00; mem_rdata = 8'h00;
    step();
    clear = 1'b0;
    check_eq("rst_pc", pc, 8'h00);
    check_eq("rst_ir", IR, 8'h00);
    check_eq("rst_valid", ir_valid, 0);
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_busy", fetch_busy, 0);
    check_eq("rst_fault", fetch_fault, 0);
    check_eq("rst_addr", mem_addr, 8'h00);

    // Idle hold, including an ack while idle that must be ignored
    for (int i = 0; i < 10; i++) begin
      mem_ack = (i == 4); mem_rdata = 8'hFF;
      step();
    end
    mem_ack = 1'b0;
    check_eq("idle_pc", pc, 8'h00);
    check_eq("idle_ir", IR, 8'h00);
    check_eq("idle_valid", ir_valid, 0);
    check_eq("idle_req", mem_req, 0);

    // Single-cycle fetch
    clock_enable = 1'b1; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_eq("f1_req", mem_req, 1);
    check_eq("f1_addr", mem_addr, 8'h00);
    check_eq("f1_valid_low", ir_valid, 0);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check_eq("f1_req_drop", mem_req, 0);
    check_eq("f1_ir", IR, 8'hA5);
    check_eq("f1_valid", ir_valid, 1);
    pc_inc = 1'b1;
    step();
    pc_inc = 1'b0;
    check_eq("f1_pcinc", pc, 8'h01);

    // Slow memory with jump mid-wait
    pc_load = 1'b1; jump_target = 8'h00;
    step();
    pc_load = 1'b0;
    check_eq("slow_pc0", pc, 8'h00);
    n = 0;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    if (fetch_busy) n++;
    pc_load = 1'b1; jump_target = 8'h40;
    step();
    pc_load = 1'b0;
    if (fetch_busy) n++;
    check_eq("slow_pc_mid", pc, 8'h40);
    check_eq("slow_addr_mid", mem_addr, 8'h00);
    step();
    if (fetch_busy) n++;
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    if (fetch_busy) n++;
    check_eq("slow_busy_cycles", n, 3);
    check_eq("slow_ir", IR, 8'h3C);
    check_eq("slow_valid", ir_valid, 1);
    check_eq("slow_addr", mem_addr, 8'h00);
    check_eq("slow_pc", pc, 8'h40);

    // Timeout with clock_enable dropped during the wait
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0; clock_enable = 1'b0;
    check_eq("to_addr", mem_addr, 8'h40);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    check_eq("to_req_cycles", n, 15);
    check_eq("to_ir", IR, 8'h00);
    check_eq("to_fault", fetch_fault, 1);
    check_eq("to_valid", ir_valid, 1);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    check_eq("to_late_ack_ir", IR, 8'h00);
    check_eq("to_late_ack_req", mem_req, 0);

    // PC arithmetic
    clock_enable = 1'b1; pc_load = 1'b1; jump_target = 8'hFF;
    step();
    pc_load = 1'b0;
    check_eq("pc_ff", pc, 8'hFF);
    pc_inc = 1'b1;
    step();
    check_eq("pc_wrap", pc, 8'h00);
    pc_load = 1'b1; jump_target = 8'h7E;
    step();
    check_eq("pc_load_wins", pc, 8'h7E);
    clock_enable = 1'b0; jump_target = 8'h11;
    step();
    pc_inc = 1'b0; pc_load = 1'b0;
    check_eq("pc_ce_low", pc, 8'h7E);
    check_eq("fault_sticky", fetch_fault, 1);

    // Clear mid-WAIT, then a late ack
    clock_enable = 1'b1; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    check_eq("clr_in_wait", mem_req, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clr_req", mem_req, 0);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    step();
    mem_ack = 1'b0;
    check_eq("clr_late_req", mem_req, 0);
    check_eq("clr_ir", IR, 8'h00);
    check_eq("clr_valid", ir_valid, 0);
    check_eq("clr_pc", pc, 8'h00);
    check_eq("clr_fault", fetch_fault, 0);

    // Ack on the timeout edge: data wins, no fault
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check_eq("edge_req_still", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    step();
    mem_ack = 1'b0;
    check_eq("edge_ir", IR, 8'h5A);
    check_eq("edge_fault", fetch_fault, 0);
    check_eq("edge_req", mem_req, 0);
    check_eq("edge_valid", ir_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction decoder. It holds the program counter and the instruction register (IR). On the decoder's fetch command it runs a request/acknowledge transaction with instruction memory and latches the returned byte into IR. It also applies the decoder's increment and taken-jump commands to the PC, and reports a busy flag that the sequencer uses to stall.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of PC and memory address
- DATA_WIDTH, 8, width of IR and memory read data
- RESET_VECTOR, 8'h00, PC value after clear
- NOP_OPCODE, 8'h00, IR value after clear and after a fetch timeout
- MAX_WAIT, 15, cycles to wait for mem_ack before timeout (1..255)

Ports:
- clock  in  1  single clock, all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- clock_enable  in  1  qualifies fetch_start, pc_inc and pc_load only
- fetch_start  in  1  decoder fetch phase (en_in): fetch at current PC
- pc_inc  in  1  decoder increment phase: PC <= PC+1
- pc_load  in  1  taken jump (en_pc): PC <= jump_target
- jump_target  in  ADDR_WIDTH  jump destination
- mem_req  out  1  memory request, registered
- mem_addr  out  ADDR_WIDTH  latched fetch address, registered
- mem_ack  in  1  memory data valid this cycle
- mem_rdata  in  DATA_WIDTH  instruction byte
- IR  out  DATA_WIDTH  instruction register, feeds decoder
- pc  out  ADDR_WIDTH  program counter
- ir_valid  out  1  IR holds the result of the most recent fetch
- fetch_busy  out  1  fetch in flight; sequencer stalls while high
- fetch_fault  out  1  sticky timeout flag

## Operation
- FSM has two states: IDLE and WAIT. A wait counter is 8 bits wide.
- IDLE, on fetch_start & clock_enable:
  - go to WAIT
  - mem_req <= 1, mem_addr <= pc
  - ir_valid <= 0, wait counter <= 0
- IDLE, otherwise: mem_ack is ignored.
- WAIT: mem_req and mem_addr are held stable. A fetch_start in WAIT is ignored (no queueing).
- WAIT, mem_ack = 1:
  - IR <= mem_rdata, ir_valid <= 1
  - mem_req <= 0, go to IDLE
- WAIT, no ack, counter == MAX_WAIT-1 (timeout):
  - IR <= NOP_OPCODE, ir_valid <= 1, fetch_fault <= 1
  - mem_req <= 0, go to IDLE
- WAIT, no ack and no timeout: counter increments.
- fetch_busy equals mem_req (asserted for exactly the WAIT cycles).
- PC update, only when clock_enable = 1, in either FSM state:
  - pc_load wins: pc <= jump_target
  - else pc_inc: pc <= pc+1 modulo 2^ADDR_WIDTH (8'hFF wraps to 8'h00)
  - else hold
- A PC change during WAIT does not affect the in-flight address (mem_addr is a separate latch).
- clock_enable low: fetch_start, pc_inc and pc_load are ignored, but the WAIT handshake and timeout keep running so an acknowledge is never lost.
- fetch_fault clears only on clear.

## Timing
- Reset values (clear high at an edge):
  - pc = RESET_VECTOR, mem_addr = RESET_VECTOR
  - IR = NOP_OPCODE
  - ir_valid = 0, mem_req = 0, fetch_busy = 0, fetch_fault = 0
  - FSM = IDLE, counter = 0
- clear has priority over every other input.
- Clear during WAIT: mem_req drops after that edge; a late mem_ack is ignored.
- Latency: fetch_start sampled at edge N → mem_req high after N. The earliest ack is sampled at edge N+1, giving IR/ir_valid valid after N+1. Minimum fetch is 2 cycles, and mem_req is high for 1 cycle.
- Ack sampled on the k-th WAIT edge (k ≥ 1) → mem_req high for k cycles.
- Timeout: mem_req is high for exactly MAX_WAIT cycles, then deasserts with fetch_fault and ir_valid set on the same edge.
- Ack and timeout on the same edge: the ack wins (data latched, fetch_fault unchanged).
- Memory must hold mem_rdata valid in the ack cycle only; the unit does not sample it later.

## Test plan
- Reset then idle: clear one cycle → pc=00, IR=00, ir_valid=0, mem_req=0, fetch_fault=0, holding for 10 cycles without stimulus.
- Single-cycle fetch: pc=00, fetch_start pulse, mem_ack with rdata=A5 on the next cycle → mem_req high 1 cycle, mem_addr=00, IR=A5, ir_valid=1; then pc_inc → pc=01.
- Slow memory: ack after 3 WAIT cycles, rdata=3C, with pc_load(jump_target=40) issued mid-wait → mem_addr stays 00, IR=3C, pc=40, fetch_busy high exactly 3 cycles.
- Timeout: MAX_WAIT=15, no ack → mem_req high 15 cycles, then IR=00, fetch_fault=1, ir_valid=1; an ack one cycle later is ignored.
- PC arithmetic: pc=FF plus pc_inc → 00. pc_inc and pc_load(7E) together → 7E. pc_inc with clock_enable=0 → unchanged.
- Clear mid-WAIT: clear on the 2nd WAIT cycle, ack on the following cycle → mem_req=0 after clear, IR=00, ir_valid=0, pc=RESET_VECTOR.
